countdown_arbiter: RTL

//   Shares one WIDTH-bit down counter (timeout timer) between N_REQ requesters.
//   A round-robin arbiter grants the counter to one requester at a time.
//   The counter loads that requester's value and counts to zero, then returns a
//   one-cycle done pulse to the owner. Sits between the timeout users and the

---
 rtl/countdown_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/countdown_arbiter.sv
// Shared WIDTH-bit timeout counter, granted round-robin to one of N_REQ requesters.
// The owner's value is loaded at grant, counted to zero, then a one-cycle done pulse is returned.
module countdown_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] load_val,
    input  logic                   pause,
    input  logic                   abort,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [WIDTH-1:0]       count
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   rr_last_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   done_q;
    logic               busy_q;
    logic [WIDTH-1:0]   count_q;

    logic               found_d;
    logic [IDX_W-1:0]   winner_d;
    logic [N_REQ-1:0]   gnt_d;
    logic [WIDTH-1:0]   load_d;

    // Search starts just past the last owner, so the previous winner has lowest priority.
    always_comb begin
        int idx;
        idx      = 0;
        found_d  = 1'b0;
        winner_d = rr_last_q;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr_last_q) + k) % N_REQ;
            if (!found_d && req[idx]) begin
                found_d  = 1'b1;
                winner_d = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        gnt_d           = '0;
        gnt_d[winner_d] = 1'b1;
        load_d          = load_val[int'(winner_d)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_last_q <= IDX_W'(N_REQ - 1);
            gnt_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= '0;
                    if (found_d) begin
                        state_q   <= COUNT;
                        gnt_q     <= gnt_d;
                        count_q   <= load_d;
                        rr_last_q <= winner_d;
                        busy_q    <= 1'b1;
                    end
                end
                COUNT: begin
                    if (abort) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        count_q <= '0;
                    end else if (pause) begin
                        state_q <= COUNT;
                    end else if (count_q != '0) begin
                        count_q <= count_q - WIDTH'(1);
                    end else begin
                        // count stays at zero here, so it can never wrap
                        state_q <= DONE;
                        done_q  <= gnt_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    count_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign count = count_q;

endmodule
